// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
// Contents: rx_state_t receiver FSM states, DEFAULT_CLKS_PER_BIT (12 MHz / 115200).
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int DEFAULT_CLKS_PER_BIT = 104;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs (rx, rts, ...).
// Ports: clk, rst (sync, active-high, loads RST_VAL), d (async in), q (synchronized out).
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q, meta_d, sync_q, sync_d;
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: UART receiver (8N1, optional even parity) with an AXI-Stream byte output.
// Ports: clk, rst (sync, active-high), rx (async serial, idle high),
//        m_axis_tdata/m_axis_tvalid/m_axis_tready (one-deep registered output),
//        frame_err, overrun_err (one-cycle pulses), parity_err (only with UART_RX_PARITY_EN).
// Build option: define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  frame_err,
    output logic                  overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic                  rx_s;
    rx_state_t             state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  ferr_q, ferr_d;
    logic                  oerr_q, oerr_d;
    logic                  par_ok;
    logic                  baud_tick;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_ok_q, par_ok_d;
    logic perr_q, perr_d;
    assign par_ok     = par_ok_q;
    assign parity_err = perr_q;
`else
    assign par_ok = 1'b1;
`endif

    assign baud_tick = baud_q == FULL;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tdata_d  = tdata_q;
        // A held byte is released by the handshake; a stop-bit load below overrides this.
        tvalid_d = tvalid_q && !m_axis_tready;
        ferr_d   = 1'b0;
        oerr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d = par_ok_q;
        perr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_q == HALF) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + CW'(1);
                    if (bit_q == LAST) state_d = AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    baud_d   = '0;
                    par_ok_d = ~^{rx_s, shift_q};
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_d  = !par_ok_q;
`endif
                    if (rx_s && par_ok) begin
                        if (tvalid_q && !m_axis_tready) begin
                            oerr_d = 1'b1;
                        end else begin
                            tvalid_d = 1'b1;
                            tdata_d  = shift_q;
                        end
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ferr_q   <= ferr_d;
            oerr_q   <= oerr_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= par_ok_d;
            perr_q   <= perr_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = oerr_q;
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed self-checking bench for uart_rx_axis (CLKS_PER_BIT=16).
module tb_uart_rx_axis;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       tready = 1'b1;
    logic [7:0] tdata;
    logic       tvalid, ferr, oerr, perr;

    uart_rx_axis #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .frame_err     (ferr),
        .overrun_err   (oerr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err    (perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    logic [7:0] exp_q[$];
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int beats = 0, rise_cyc = 0, start_cyc = 0;
    logic [7:0] last_data = '0;
    logic       pv = 0, pheld = 0, pf = 0, po = 0, pp = 0;
    logic [7:0] pd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: beats must come out in the order the frames were sent and
    // each error pulse must be one that the directed test announced.
    always @(negedge clk) begin
        if (rst) begin
            pv = 0; pheld = 0; pf = 0; po = 0; pp = 0;
        end else begin
            if (tvalid && !pv) rise_cyc = cyc;
            if (pheld) chk("hold_stable", tvalid && tdata == pd, {23'd0, tvalid, tdata}, {23'd0, 1'b1, pd});
            if (tvalid && tready) begin
                beats++;
                last_data = tdata;
                if (exp_q.size() == 0) chk("unexpected_beat", 1'b0, tdata, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("beat_data", tdata == e, tdata, e);
                end
            end
            if (ferr) begin
                chk("frame_err_pulse", exp_fe > 0 && !pf, exp_fe, 1);
                if (exp_fe > 0) exp_fe--;
            end
            if (oerr) begin
                chk("overrun_err_pulse", exp_ov > 0 && !po, exp_ov, 1);
                if (exp_ov > 0) exp_ov--;
            end
            if (perr) begin
                chk("parity_err_pulse", exp_pe > 0 && !pp, exp_pe, 1);
                if (exp_pe > 0) exp_pe--;
            end
            pv = tvalid; pheld = tvalid && !tready; pd = tdata;
            pf = ferr; po = oerr; pp = perr;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok = 1, input bit par_ok = 1);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PB == 1) send_bit(^d ^ !par_ok);
        send_bit(stop_ok);
        rx = 1'b1;
    endtask

    task automatic end_test(input string t);
        chk($sformatf("%s_pending_beats", t), exp_q.size() == 0, exp_q.size(), 0);
        chk($sformatf("%s_pending_frame_err", t), exp_fe == 0, exp_fe, 0);
        chk($sformatf("%s_pending_overrun", t), exp_ov == 0, exp_ov, 0);
        chk($sformatf("%s_pending_parity_err", t), exp_pe == 0, exp_pe, 0);
    endtask

    initial begin
        int b0, lat;
        tick(3);
        chk("reset_tvalid", tvalid == 1'b0, tvalid, 0);
        chk("reset_tdata", tdata == 8'h00, tdata, 0);
        chk("reset_frame_err", ferr == 1'b0, ferr, 0);
        chk("reset_overrun_err", oerr == 1'b0, oerr, 0);
        rst = 1'b0;
        tick(2 * CPB);

        b0 = beats;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5);
        tick(2 * CPB);
        lat = rise_cyc - start_cyc;
        chk("t1_beats", beats == b0 + 1, beats - b0, 1);
        chk("t1_tdata_literal", last_data == 8'hA5, last_data, 8'hA5);
        chk("t1_latency", lat >= 150 + 16 * PB && lat <= 160 + 16 * PB, lat, 156 + 16 * PB);
        end_test("t1");

        b0 = beats;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00);
        send_frame(8'hFF);
        tick(2 * CPB);
        chk("t2_beats", beats == b0 + 2, beats - b0, 2);
        chk("t2_last_literal", last_data == 8'hFF, last_data, 8'hFF);
        end_test("t2");

        b0 = beats;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        chk("t3_beats", beats == b0, beats - b0, 0);
        chk("t3_idle", dut.state_q == uart_pkg::IDLE, 32'(dut.state_q), 32'(uart_pkg::IDLE));
        end_test("t3");

        b0 = beats;
        exp_fe = 1;
        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        chk("t4_beats", beats == b0, beats - b0, 0);
        chk("t4_tvalid", tvalid == 1'b0, tvalid, 0);
        end_test("t4");

        b0 = beats;
        tready = 1'b0;
        exp_q.push_back(8'h11);
        exp_ov = 1;
        send_frame(8'h11);
        send_frame(8'h22);
        tick(2 * CPB);
        chk("t5_held_literal", tvalid && tdata == 8'h11, {23'd0, tvalid, tdata}, {23'd0, 1'b1, 8'h11});
        tready = 1'b1;
        tick(1);
        chk("t5_tvalid_falls", tvalid == 1'b0, tvalid, 0);
        chk("t5_beats", beats == b0 + 1, beats - b0, 1);
        end_test("t5");

        b0 = beats;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        tick(CPB / 2);
        rst = 1'b1;
        tick(2);
        chk("t6_reset_tvalid", tvalid == 1'b0, tvalid, 0);
        rst = 1'b0;
        rx = 1'b1;
        tick(20 * CPB);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3);
        tick(2 * CPB);
        chk("t6_beats", beats == b0 + 1, beats - b0, 1);
        chk("t6_tdata_literal", last_data == 8'hC3, last_data, 8'hC3);
        end_test("t6");

`ifdef UART_RX_PARITY_EN
        b0 = beats;
        exp_pe = 1;
        send_frame(8'hC3, 1'b1, 1'b0);
        tick(2 * CPB);
        chk("t7_beats", beats == b0, beats - b0, 0);
        end_test("t7");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
